// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: write strobes are queued in a circular FIFO and
// serialised with configurable baud divisor, data bits, parity and stop bits.
module uart_tx_fifo #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic [DATA_WIDTH-1:0]   uart_tx_data,
  input  logic                    uart_tx_en,
  input  logic                    overflow_clr,
  output logic                    fifo_full,
  output logic                    fifo_empty,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    overflow,
  output logic                    busy,
  output logic                    uart_txd
);

  localparam int unsigned DIV = CLK_FREQ / BAUD;
  localparam int unsigned CW  = $clog2(DIV);
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int unsigned SW  = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;
  localparam bit          HAS_PAR = (PARITY != 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          baud_q, baud_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [SW-1:0]          stop_q, stop_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   txd_q, txd_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PW:0]            count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic [DATA_BITS-1:0]   mem_q [DEPTH];

  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   pop;
  logic                   baud_done;
  logic [DATA_BITS-1:0]   head;
  logic                   unused_data;

  // Only the low DATA_BITS of each write are ever transmitted.
  assign unused_data = ^uart_tx_data;

  assign full      = (count_q == (PW + 1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign push      = uart_tx_en & ~full;
  assign pop       = (state_q == ST_IDLE) & ~empty;
  assign baud_done = (baud_q == CW'(DIV - 1));
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PW + 1)'(1);
      2'b01:   count_d = count_q - (PW + 1)'(1);
      default: count_d = count_q;
    endcase
    // A dropped write outranks a simultaneous clear.
    if (uart_tx_en && full) begin
      ovf_d = 1'b1;
    end else if (overflow_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + CW'(1);
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    par_d   = par_q;
    txd_d   = txd_q;
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        txd_d  = 1'b1;
        if (pop) begin
          state_d = ST_START;
          shift_d = head;
          par_d   = (PARITY == 1) ? ~^head : ^head;
          txd_d   = 1'b0;
          bit_d   = '0;
          stop_d  = '0;
        end
      end
      ST_START: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = ST_DATA;
          txd_d   = shift_q[0];
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == BW'(DATA_BITS - 1)) begin
            if (HAS_PAR) begin
              state_d = ST_PARITY;
              txd_d   = par_q;
            end else begin
              state_d = ST_STOP;
              txd_d   = 1'b1;
              stop_d  = '0;
            end
          end else begin
            // shift_q[0] is the bit on the wire, so the next one is at [1].
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
            bit_d   = bit_q + BW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = ST_STOP;
          txd_d   = 1'b1;
          stop_d  = '0;
        end
      end
      ST_STOP: begin
        txd_d = 1'b1;
        if (baud_done) begin
          baud_d = '0;
          if (stop_q == SW'(STOP_BITS - 1)) begin
            state_d = ST_IDLE;
          end else begin
            stop_d = stop_q + SW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wr_ptr_q] <= uart_tx_data[DATA_BITS-1:0];
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      stop_q   <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      txd_q    <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      txd_q    <= txd_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign fifo_full  = full;
  assign fifo_empty = empty;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;
  assign busy       = (state_q != ST_IDLE) | ~empty;
  assign uart_txd   = txd_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three framings (8N1, 7E2, 7O2) share one stimulus
// stream; each is checked every cycle against a queue/waveform model.
module tb_uart_tx_fifo;

  localparam int DIV   = 10;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] data;
  logic       en;
  logic       clr;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int DB  = (g == 0) ? 8 : 7;
    localparam int PAR = (g == 0) ? 0 : ((g == 1) ? 2 : 1);
    localparam int SB  = (g == 0) ? 1 : 2;

    logic       txd, full, empty, ovf, busy;
    logic [2:0] cnt;

    uart_tx_fifo #(
      .CLK_FREQ  (50_000_000),
      .BAUD      (5_000_000),
      .DATA_WIDTH(8),
      .DATA_BITS (DB),
      .PARITY    (PAR),
      .STOP_BITS (SB),
      .DEPTH     (DEPTH)
    ) u_dut (
      .sys_clk     (clk),
      .sys_rst_n   (rst_n),
      .uart_tx_data(data),
      .uart_tx_en  (en),
      .overflow_clr(clr),
      .fifo_full   (full),
      .fifo_empty  (empty),
      .fifo_count  (cnt),
      .overflow    (ovf),
      .busy        (busy),
      .uart_txd    (txd)
    );

    // Model: byte queue plus the per-cycle line levels of the frame in flight.
    logic [7:0] q[$];
    bit         w[$];
    bit         in_frame = 1'b0;
    bit         m_txd = 1'b1;
    bit         m_ovf = 1'b0;
    bit         full_pre;
    bit         p;
    logic [7:0] b;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q.delete();
        w.delete();
        in_frame = 1'b0;
        m_txd    = 1'b1;
        m_ovf    = 1'b0;
      end else begin
        full_pre = (q.size() == DEPTH);
        if (!in_frame && q.size() != 0) begin
          b = q.pop_front();
          p = (PAR == 1);
          repeat (DIV) w.push_back(1'b0);
          for (int i = 0; i < DB; i++) begin
            p ^= b[i];
            repeat (DIV) w.push_back(b[i]);
          end
          if (PAR != 0) repeat (DIV) w.push_back(p);
          repeat (SB * DIV) w.push_back(1'b1);
        end
        if (en && !full_pre) q.push_back(data);
        if (en && full_pre) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (w.size() != 0) begin
          m_txd    = w.pop_front();
          in_frame = 1'b1;
        end else begin
          m_txd    = 1'b1;
          in_frame = 1'b0;
        end
      end
    end

    always @(negedge clk) begin
      chk($sformatf("i%0d_txd", g),   32'(txd),   32'(m_txd));
      chk($sformatf("i%0d_count", g), 32'(cnt),   32'(q.size()));
      chk($sformatf("i%0d_full", g),  32'(full),  32'(q.size() == DEPTH));
      chk($sformatf("i%0d_empty", g), 32'(empty), 32'(q.size() == 0));
      chk($sformatf("i%0d_ovf", g),   32'(ovf),   32'(m_ovf));
      chk($sformatf("i%0d_busy", g),  32'(busy),  32'(in_frame || q.size() != 0));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((g_inst[0].busy || g_inst[1].busy || g_inst[2].busy) && n < limit) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(g_inst[0].busy || g_inst[1].busy || g_inst[2].busy), 32'd0);
    step();
  endtask

  // Entered just after the start edge of an 8N1 frame on instance 0.
  task automatic frame_pins0(input string nm, input logic [9:0] e);
    for (int k = 0; k < 10; k++) begin
      repeat ((k == 0) ? 5 : 10) step();
      chk($sformatf("%s_bit%0d", nm, k), 32'(g_inst[0].txd), 32'(e[k]));
    end
  endtask

  initial begin
    logic [9:0]  e0;
    logic [10:0] e1;
    logic [10:0] e2;
    en = 1'b0; clr = 1'b0; data = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd",   32'(g_inst[0].txd),   32'd1);
    chk("rst_empty", 32'(g_inst[0].empty), 32'd1);
    chk("rst_full",  32'(g_inst[0].full),  32'd0);
    chk("rst_count", 32'(g_inst[0].cnt),   32'd0);
    chk("rst_ovf",   32'(g_inst[0].ovf),   32'd0);
    chk("rst_busy",  32'(g_inst[0].busy),  32'd0);
    rst_n = 1'b1;
    step(); step();

    // Single byte 0x55; data changes right after the strobe.
    data = 8'h55; en = 1'b1; step();
    en = 1'b0; data = 8'hAA;
    chk("s55_count", 32'(g_inst[0].cnt), 32'd1);
    chk("s55_idle",  32'(g_inst[0].txd), 32'd1);
    step();
    chk("s55_start_edge", 32'(g_inst[0].txd), 32'd0);
    frame_pins0("s55", {1'b1, 8'h55, 1'b0});
    repeat (4) step();
    chk("s55_busy_last_stop", 32'(g_inst[0].busy), 32'd1);
    step();
    chk("s55_busy_after", 32'(g_inst[0].busy), 32'd0);
    wait_idle(400);

    // 0x83 on all framings: parity pinned on the 7-bit instances.
    e0 = {1'b1, 8'h83, 1'b0};
    e1 = {2'b11, 1'b0, 7'h03, 1'b0};
    e2 = {2'b11, 1'b1, 7'h03, 1'b0};
    data = 8'h83; en = 1'b1; step();
    en = 1'b0; data = 8'h00;
    step();
    for (int k = 0; k < 11; k++) begin
      repeat ((k == 0) ? 5 : 10) step();
      chk($sformatf("p83_even_bit%0d", k), 32'(g_inst[1].txd), 32'(e1[k]));
      chk($sformatf("p83_odd_bit%0d", k),  32'(g_inst[2].txd), 32'(e2[k]));
      if (k < 10) chk($sformatf("p83_8n1_bit%0d", k), 32'(g_inst[0].txd), 32'(e0[k]));
    end
    repeat (4) step();
    chk("p83_busy_last_stop", 32'(g_inst[1].busy), 32'd1);
    step();
    chk("p83_busy_after", 32'(g_inst[1].busy), 32'd0);
    wait_idle(400);

    // Burst of five into DEPTH=4, then overflow handling.
    en = 1'b1;
    data = 8'h41; step();
    chk("burst_cnt0", 32'(g_inst[0].cnt), 32'd1);
    data = 8'h42; step();
    chk("burst_cnt1", 32'(g_inst[0].cnt), 32'd1);
    data = 8'h43; step();
    data = 8'h44; step();
    data = 8'h45; step();
    en = 1'b0;
    chk("burst_cnt4", 32'(g_inst[0].cnt),  32'd4);
    chk("burst_full", 32'(g_inst[0].full), 32'd1);
    chk("burst_ovf",  32'(g_inst[0].ovf),  32'd0);
    data = 8'h99; en = 1'b1; step();
    en = 1'b0;
    chk("ovf_set",   32'(g_inst[0].ovf), 32'd1);
    chk("ovf_count", 32'(g_inst[0].cnt), 32'd4);
    clr = 1'b1; step();
    clr = 1'b0;
    chk("ovf_clr", 32'(g_inst[0].ovf), 32'd0);
    data = 8'h9A; en = 1'b1; clr = 1'b1; step();
    en = 1'b0; clr = 1'b0;
    chk("ovf_set_wins", 32'(g_inst[0].ovf), 32'd1);
    clr = 1'b1; step();
    clr = 1'b0;
    chk("ovf_clr2", 32'(g_inst[0].ovf), 32'd0);
    // 0x41 finishes and 0x42 pops 94 edges from here; write on that edge.
    repeat (93) step();
    chk("fullpop_pre_full", 32'(g_inst[0].full), 32'd1);
    data = 8'h77; en = 1'b1; step();
    en = 1'b0;
    chk("fullpop_count", 32'(g_inst[0].cnt), 32'd3);
    chk("fullpop_ovf",   32'(g_inst[0].ovf), 32'd1);
    chk("fullpop_start", 32'(g_inst[0].txd), 32'd0);
    wait_idle(2000);
    clr = 1'b1; step(); clr = 1'b0;

    // Asynchronous reset in the middle of data bit 4 of 0x0F with a byte queued.
    data = 8'h0F; en = 1'b1; step();
    data = 8'h11; step();
    en = 1'b0;
    repeat (54) step();
    chk("arst_pre_txd", 32'(g_inst[0].txd), 32'd0);
    chk("arst_pre_cnt", 32'(g_inst[0].cnt), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_txd",   32'(g_inst[0].txd),   32'd1);
    chk("arst_empty", 32'(g_inst[0].empty), 32'd1);
    chk("arst_count", 32'(g_inst[0].cnt),   32'd0);
    chk("arst_busy",  32'(g_inst[0].busy),  32'd0);
    chk("arst_txd_7e2", 32'(g_inst[1].txd), 32'd1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    data = 8'h01; en = 1'b1; step();
    en = 1'b0;
    step();
    chk("r01_start_edge", 32'(g_inst[0].txd), 32'd0);
    frame_pins0("r01", {1'b1, 8'h01, 1'b0});
    wait_idle(400);

    // Random traffic: light load, then heavy load with overflows.
    for (int i = 0; i < 3000; i++) begin
      data = 8'($urandom);
      en   = ($urandom_range(0, (i < 1500) ? 39 : 3) == 0);
      clr  = ($urandom_range(0, 49) == 0);
      step();
    end
    en = 1'b0; clr = 1'b0;
    wait_idle(3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
